key_sw_debouncer: RTL and testbench
===================================

// Module: key_sw_debouncer
//
// PURPOSE
//   Input-side conditioning for board keys and switches. It is the counterpart of the
//   segment-display output path.
//   - Synchronizes raw asynchronous key/switch levels into the clk domain.
//   - Debounces each bit independently.
//   - Normalizes polarity, so 1 always means pressed/on.
//   - Emits one-cycle rise/fall pulses per bit.
//   Sits between the top-level key/sw pins and any logic consuming user input
//   (reset generation, counters, display selection).
//
// PARAMETERS
//   N                12         number of input bits; raw_in = { key[1:0], sw[9:0] }
//   DEBOUNCE_CYCLES  500000     cycles an input must hold stable to be accepted (10 ms @ 50 MHz); legal range >= 1
//   CNT_W            19         counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
//   INVERT_MASK      12'hC00    bit set = raw input is active-low (keys); inverted after synchronization
//
// PORTS
//   clk         in   1   system clock (max10_clk1_50)
//   reset_n     in   1   asynchronous, active-low reset
//   raw_in      in   N   raw pin levels, asynchronous to clk
//   level       out  N   debounced, polarity-normalized level (1 = pressed/on)
//   rise        out  N   one-cycle pulse: level bit went 0->1
//   fall        out  N   one-cycle pulse: level bit went 1->0
//   any_change  out  1   OR of (rise | fall); registered in the same cycle as the pulses
//
// BEHAVIOUR
//   Reset (reset_n = 0, asynchronous)
//     - sync1 and sync2 flops load INVERT_MASK, so the normalized value reads 0.
//     - Counters load 0.
//     - level, rise, fall and any_change all load 0.
//   Synchronizer
//     - Two flops per bit: sync1 <= raw_in, sync2 <= sync1.
//     - Normalized input: s = sync2 ^ INVERT_MASK.
//   Per-bit debounce (independent counter cnt[i], CNT_W bits)
//     - s[i] == level[i]: cnt[i] <= 0.
//     - s[i] != level[i] and cnt[i] != DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i] + 1.
//     - s[i] != level[i] and cnt[i] == DEBOUNCE_CYCLES-1:
//         level[i] <= s[i]; cnt[i] <= 0; rise[i] <= s[i]; fall[i] <= ~s[i].
//     - Otherwise rise[i] <= 0 and fall[i] <= 0.
//   Latency
//     - raw_in changes before edge 0 and stays stable: level, rise/fall and
//       any_change update at edge 2 + DEBOUNCE_CYCLES.
//     - Pulses are high for exactly one cycle.
//   Glitch rejection
//     - Any return of s[i] to level[i] before the count completes clears cnt[i].
//     - A later mismatch restarts the full DEBOUNCE_CYCLES count.
//     - A mismatch lasting DEBOUNCE_CYCLES-1 cycles or fewer never changes level.
//   Boundaries
//     - Simultaneous events: bits changing together produce simultaneous pulses;
//       no priority between bits, no cross-bit interaction.
//     - Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
//     - DEBOUNCE_CYCLES = 1: level follows s one edge after sync2 (total latency 3).
//     - Reset mid-count: all state clears immediately. An input still active after
//       reset release is accepted only after a full 2 + DEBOUNCE_CYCLES edges, with
//       a rise pulse (power-up press is reported as an event).
//   No combinational path from raw_in to any output; all outputs are registered.
//
// TESTING  (bench uses DEBOUNCE_CYCLES = 4)
//   1. Reset: reset_n=0 with raw_in=12'hC00 (keys idle high)
//        -> level=0, rise=0, fall=0, any_change=0, held for 20 cycles after release.
//   2. raw_in[0] 0->1 at edge 0, held
//        -> level[0]=1 and rise[0]=1 at edge 6; rise low at edge 7; any_change pulses with it.
//   3. raw_in[1] high for 3 cycles then low
//        -> level[1], rise[1], any_change remain 0 throughout.
//   4. raw_in[10] (key0, active-low) 1->0 held
//        -> level[10]=1, rise[10] pulse at edge 6.
//      raw_in[10] back to 1
//        -> fall[10] pulse 6 edges later, level[10]=0.
//   5. raw_in[0] 0->1, reset_n pulsed low at edge 4
//        -> level[0]=0 immediately.
//      After reset release (raw_in[0] still 1)
//        -> level[0]=1 and rise[0] exactly 6 edges later.
//   6. raw_in[3] and raw_in[7] rise on the same edge
//        -> rise[3] and rise[7] assert together for one cycle; level=12'h088.

Source files
------------

// File: rtl/key_sw_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_sw_debouncer
//  Purpose  : Two-flop synchronizer, per-bit debounce counters, polarity
//             normalization (1 = pressed/on) and one-cycle rise/fall pulses
//             for board keys and switches.
//  Revision : 1.0  initial release
// ============================================================================
module key_sw_debouncer #(
    parameter int             N               = 12,
    parameter int             DEBOUNCE_CYCLES = 500000,
    parameter int             CNT_W           = 19,
    parameter logic [N-1:0]   INVERT_MASK     = 12'hC00
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     raw_in,
    output logic [N-1:0]     level,
    output logic [N-1:0]     rise,
    output logic [N-1:0]     fall,
    output logic             any_change
);

    // Terminal count: a mismatch seen while the counter sits here is accepted.
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_level;
    logic [N-1:0] r_rise;
    logic [N-1:0] r_fall;
    logic         r_any;

    logic [N-1:0] w_s;      // synchronized, polarity-normalized input
    logic [N-1:0] w_diff;   // input disagrees with the accepted level
    logic [N-1:0] w_done;   // disagreement has lasted the full debounce time

    // Two-flop synchronizer; reset value makes the normalized input read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= INVERT_MASK;
            r_sync2 <= INVERT_MASK;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Normalize polarity after synchronization so the flops see raw pin levels.
    always_comb begin
        w_s    = r_sync2 ^ INVERT_MASK;
        w_diff = w_s ^ r_level;
    end

    // One independent counter per bit; no bit ever looks at another.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;

            // Count consecutive mismatching cycles; any agreement restarts it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (!w_diff[gi] || w_done[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_done[gi] = w_diff[gi] && (r_cnt == c_CNT_MAX);
        end
    endgenerate

    // Accept new levels and register the edge pulses in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
        end else begin
            r_level <= r_level ^ w_done;
            r_rise  <= w_done & w_s;
            r_fall  <= w_done & ~w_s;
            r_any   <= |w_done;
        end
    end

    assign level      = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = r_any;

endmodule
`default_nettype wire

// File: tb/tb_key_sw_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sw_debouncer
//  Purpose  : Self-checking bench for key_sw_debouncer: vector table, corner
//             sequences and randomized stimulus against a window-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_sw_debouncer;

    localparam logic [11:0] c_MASK = 12'hC00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] raw_in = 12'hC00;

    logic [11:0] level4, rise4, fall4;
    logic        any4;
    logic [11:0] level1, rise1, fall1;
    logic        any1;

    int checks = 0;
    int errors = 0;

    key_sw_debouncer #(
        .N(12), .DEBOUNCE_CYCLES(4), .CNT_W(3), .INVERT_MASK(12'hC00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .level(level4), .rise(rise4), .fall(fall4), .any_change(any4)
    );

    key_sw_debouncer #(
        .N(12), .DEBOUNCE_CYCLES(1), .CNT_W(1), .INVERT_MASK(12'hC00)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .level(level1), .rise(rise1), .fall(fall1), .any_change(any1)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a bit is accepted when the last D normalized samples
    // seen by the debouncer (raw_in delayed two edges) all disagree with the
    // currently accepted level.
    // ------------------------------------------------------------------
    logic [11:0] raw_q[$];
    logic [11:0] m_level[2] = '{12'h000, 12'h000};
    logic [11:0] m_rise[2]  = '{12'h000, 12'h000};
    logic [11:0] m_fall[2]  = '{12'h000, 12'h000};

    task automatic model_step();
        int          d;
        logic [11:0] nl, r, f, smp;
        bit          all;
        if (!reset_n) begin
            raw_q.delete();
            repeat (6) raw_q.push_back(c_MASK);
            for (int k = 0; k < 2; k++) begin
                m_level[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                d  = (k == 0) ? 4 : 1;
                nl = m_level[k]; r = '0; f = '0;
                for (int b = 0; b < 12; b++) begin
                    all = 1'b1;
                    for (int j = 0; j < d; j++) begin
                        smp = raw_q[raw_q.size() - 2 - j] ^ c_MASK;
                        if (smp[b] == m_level[k][b]) all = 1'b0;
                    end
                    if (all) begin
                        nl[b] = ~m_level[k][b];
                        if (nl[b]) r[b] = 1'b1; else f[b] = 1'b1;
                    end
                end
                m_level[k] = nl; m_rise[k] = r; m_fall[k] = f;
            end
            raw_q.push_back(raw_in);
            if (raw_q.size() > 12) void'(raw_q.pop_front());
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every edge; outputs compared 2 ns later.
    always @(posedge clk) begin
        model_step();
        #2;
        check("mdl_level4", level4, m_level[0]);
        check("mdl_rise4",  rise4,  m_rise[0]);
        check("mdl_fall4",  fall4,  m_fall[0]);
        check("mdl_any4",   {11'd0, any4}, {11'd0, |(m_rise[0] | m_fall[0])});
        check("mdl_level1", level1, m_level[1]);
        check("mdl_rise1",  rise1,  m_rise[1]);
        check("mdl_fall1",  fall1,  m_fall[1]);
        check("mdl_any1",   {11'd0, any1}, {11'd0, |(m_rise[1] | m_fall[1])});
    end

    task automatic drive(input logic [11:0] v);
        @(negedge clk);
        raw_in = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [11:0] raw;
        int          hold;
        logic [11:0] exp_level;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{12'hC00, 20, 12'h000};
        tbl[1]  = '{12'hC01,  5, 12'h000};
        tbl[2]  = '{12'hC01,  1, 12'h001};
        tbl[3]  = '{12'hC03,  3, 12'h001};
        tbl[4]  = '{12'hC01, 10, 12'h001};
        tbl[5]  = '{12'hC03,  4, 12'h001};
        tbl[6]  = '{12'hC01,  2, 12'h003};
        tbl[7]  = '{12'hC01,  6, 12'h001};
        tbl[8]  = '{12'h801,  6, 12'h401};
        tbl[9]  = '{12'hC01,  5, 12'h401};
        tbl[10] = '{12'hC01,  1, 12'h001};
        tbl[11] = '{12'hC89,  6, 12'h089};
        tbl[12] = '{12'hC00,  6, 12'h000};
        tbl[13] = '{12'h3FF,  6, 12'hFFF};
        tbl[14] = '{12'hC00,  6, 12'h000};

        // Reset state with keys idle high.
        repeat (3) @(negedge clk);
        #1;
        check("rst_level", level4, 12'h000);
        check("rst_rise",  rise4,  12'h000);
        check("rst_fall",  fall4,  12'h000);
        check("rst_any",   {11'd0, any4}, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].raw);
            tick(tbl[i].hold);
            check($sformatf("tbl%0d_level", i), level4, tbl[i].exp_level);
        end

        // Single press: pulse appears on edge 6 only.
        drive(12'hC01);
        tick(5);
        check("p_rise_early", rise4, 12'h000);
        check("p_level_early", level4, 12'h000);
        tick(1);
        check("p_level", level4, 12'h001);
        check("p_rise", rise4, 12'h001);
        check("p_any", {11'd0, any4}, 12'h001);
        tick(1);
        check("p_rise_end", rise4, 12'h000);
        check("p_any_end", {11'd0, any4}, 12'h000);
        drive(12'hC00);
        tick(8);

        // Single-cycle debounce: total latency 3.
        drive(12'hC10);
        tick(2);
        check("d1_level_early", level1, 12'h000);
        tick(1);
        check("d1_level", level1, 12'h010);
        check("d1_rise", rise1, 12'h010);
        tick(1);
        check("d1_rise_end", rise1, 12'h000);
        drive(12'hC00);
        tick(8);

        // Two bits together.
        drive(12'hC88);
        tick(6);
        check("sim_rise", rise4, 12'h088);
        check("sim_level", level4, 12'h088);
        tick(1);
        check("sim_rise_end", rise4, 12'h000);
        drive(12'hC00);
        tick(8);

        // Reset mid-count, input held through reset.
        drive(12'hC01);
        tick(3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rmc_level", level4, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        tick(5);
        check("rmc_level_early", level4, 12'h000);
        tick(1);
        check("rmc_level", level4, 12'h001);
        check("rmc_rise", rise4, 12'h001);

        // Reset while pressed: clears at once, power-up press reported again.
        tick(2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rp_level_async", level4, 12'h000);
        check("rp_rise_async", rise4, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        tick(5);
        check("rp_level_early", level4, 12'h000);
        tick(1);
        check("rp_level", level4, 12'h001);
        check("rp_rise", rise4, 12'h001);
        drive(12'hC00);
        tick(8);

        // Randomized bit toggles, glitches and occasional resets.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset_n = 1'b1;
            end else begin
                logic [11:0] flip;
                flip = 12'(1 << $urandom_range(0, 11));
                if ($urandom_range(0, 3) == 0) flip = flip | 12'($urandom);
                @(negedge clk);
                raw_in = raw_in ^ flip;
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
